// File: rtl/stream_burst_source.sv
// rtl/stream_burst_source.sv - valid/ready burst traffic source with programmable length, seed, step and gap
module stream_burst_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  word_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                r_state, w_state;
  logic [LEN_WIDTH-1:0]  r_len, w_len;
  logic [DATA_WIDTH-1:0] r_step, w_step;
  logic [GAP_WIDTH-1:0]  r_gap, w_gap;
  logic [GAP_WIDTH-1:0]  r_gap_cnt, w_gap_cnt;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic [LEN_WIDTH-1:0]  r_count, w_count;
  logic                  r_valid, w_valid;
  logic                  r_last, w_last;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  w_hs;
  logic [LEN_WIDTH-1:0]  w_count_inc;
  logic [LEN_WIDTH-1:0]  w_last_idx;

  assign w_hs        = r_valid & out_ready;
  assign w_count_inc = r_count + LEN_WIDTH'(1);
  assign w_last_idx  = r_len - LEN_WIDTH'(1);

  always_comb begin
    w_state   = r_state;
    w_len     = r_len;
    w_step    = r_step;
    w_gap     = r_gap;
    w_gap_cnt = r_gap_cnt;
    w_data    = r_data;
    w_count   = r_count;
    w_valid   = r_valid;
    w_last    = r_last;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len   = cfg_len;
          w_step  = cfg_step;
          w_gap   = cfg_gap;
          w_data  = cfg_seed;
          w_count = '0;
          if (cfg_len != '0) begin
            w_state = S_SEND;
            w_valid = 1'b1;
            w_last  = (cfg_len == LEN_WIDTH'(1));
          end else begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_done  = 1'b1;
          end
        end
      end
      S_SEND: begin
        // data/last only move on a handshake, so a stalled word stays stable
        if (w_hs) begin
          w_count = w_count_inc;
          w_data  = r_data + r_step;
          if (r_last) begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_done  = 1'b1;
          end else if (r_gap != '0) begin
            w_state   = S_GAP;
            w_valid   = 1'b0;
            w_last    = 1'b0;
            w_gap_cnt = r_gap;
          end else begin
            w_last = (w_count_inc == w_last_idx);
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_WIDTH'(1)) begin
          w_state = S_SEND;
          w_valid = 1'b1;
          w_last  = (r_count == w_last_idx);
        end else begin
          w_gap_cnt = r_gap_cnt - GAP_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
        w_last  = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_step    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_data    <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_len     <= w_len;
      r_step    <= w_step;
      r_gap     <= w_gap;
      r_gap_cnt <= w_gap_cnt;
      r_data    <= w_data;
      r_count   <= w_count;
      r_valid   <= w_valid;
      r_last    <= w_last;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign out_last   = r_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_count;

endmodule

// File: tb/tb_stream_burst_source.sv
// tb/tb_stream_burst_source.sv - directed table and sequence bench for stream_burst_source
module tb_stream_burst_source;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_step;
  logic [7:0]  cfg_gap;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] word_count;

  int checks;
  int failures;

  stream_burst_source dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_seed   (cfg_seed),
    .cfg_step   (cfg_step),
    .cfg_gap    (cfg_gap),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic [31:0] seed;
    logic [31:0] step;
    logic [7:0]  gap;
    logic        ready;
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        b;
    logic        dn;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] len, input logic [31:0] seed,
                       input logic [31:0] step, input logic [7:0] gap, input logic rdy);
    start     = s;
    cfg_len   = len;
    cfg_seed  = seed;
    cfg_step  = step;
    cfg_gap   = gap;
    out_ready = rdy;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic l,
                         input logic b, input logic dn, input logic [15:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".done"},  32'(done),      32'(dn));
    chk({tag, ".count"}, 32'(word_count), 32'(c));
    if (v) chk({tag, ".data"}, out_data, d);
  endtask

  initial begin
    vec_t   r;
    logic   gv[9];
    logic [31:0] gd[9];
    logic   gdn[9];
    logic   gl[9];
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b0, 16'd0, 32'd0, 32'd0, 8'd0, 1'b0);

    // reset state
    repeat (3) tick();
    chk_out("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset.data", out_data, 32'd0);
    rst = 1'b0;
    tick();

    // burst of 4 back to back
    tbl.push_back('{1'b1, 16'd4, 32'h100, 32'd1, 8'd0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 16'd0});
    tbl.push_back('{1'b0, 16'd0, 32'h0,   32'd0, 8'd0, 1'b1, 1'b1, 32'h101, 1'b0, 1'b1, 1'b0, 16'd1});
    tbl.push_back('{1'b0, 16'd0, 32'h0,   32'd0, 8'd0, 1'b1, 1'b1, 32'h102, 1'b0, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{1'b0, 16'd0, 32'h0,   32'd0, 8'd0, 1'b1, 1'b1, 32'h103, 1'b1, 1'b1, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 16'd0, 32'h0,   32'd0, 8'd0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 16'd4});
    tbl.push_back('{1'b0, 16'd0, 32'h0,   32'd0, 8'd0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 16'd4});
    // data wrap
    tbl.push_back('{1'b1, 16'd3, 32'hFFFFFFFE, 32'd1, 8'd0, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 16'd0});
    tbl.push_back('{1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 16'd1});
    tbl.push_back('{1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd3});
    // zero-length burst
    tbl.push_back('{1'b1, 16'd0, 32'h55, 32'd1, 8'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{1'b0, 16'd0, 32'h0,  32'd0, 8'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b0, 16'd0, 32'h0,  32'd0, 8'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0});

    foreach (tbl[i]) begin
      r = tbl[i];
      drive(r.start, r.len, r.seed, r.step, r.gap, r.ready);
      tick();
      chk_out($sformatf("tbl%0d", i), r.v, r.d, r.l, r.b, r.dn, r.c);
    end

    // backpressure holds data and last
    drive(1'b1, 16'd2, 32'hA5A5A5A5, 32'd1, 8'd0, 1'b0);
    tick();
    drive(1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("stall%0d", k), 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 16'd0);
      tick();
    end
    chk_out("stall3", 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 16'd0);
    out_ready = 1'b1;
    tick();
    chk_out("stall_w1", 1'b1, 32'hA5A5A5A6, 1'b1, 1'b1, 1'b0, 16'd1);
    out_ready = 1'b0;
    tick();
    chk_out("stall_last", 1'b1, 32'hA5A5A5A6, 1'b1, 1'b1, 1'b0, 16'd1);
    out_ready = 1'b1;
    tick();
    chk_out("stall_done", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd2);
    tick();

    // gap of 2 between words, none after the last
    gv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    gd  = '{32'h10, 32'h0, 32'h0, 32'h11, 32'h0, 32'h0, 32'h12, 32'h0, 32'h0};
    gl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    gdn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 16'd3, 32'h10, 32'd1, 8'd2, 1'b1);
    tick();
    drive(1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("gap%0d.valid", k), 32'(out_valid), 32'(gv[k]));
      chk($sformatf("gap%0d.last", k), 32'(out_last), 32'(gl[k]));
      chk($sformatf("gap%0d.done", k), 32'(done), 32'(gdn[k]));
      if (gv[k]) chk($sformatf("gap%0d.data", k), out_data, gd[k]);
      tick();
    end

    // reset mid-burst after 2 of 5 words
    drive(1'b1, 16'd5, 32'h200, 32'd4, 8'd0, 1'b1);
    tick();
    drive(1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1);
    tick();
    tick();
    chk_out("pre_rst", 1'b1, 32'h208, 1'b0, 1'b1, 1'b0, 16'd2);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("post_rst%0d", k), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    end

    // fresh burst; start and cfg changes while busy are ignored
    drive(1'b1, 16'd3, 32'h300, 32'd2, 8'd0, 1'b1);
    tick();
    chk_out("fresh0", 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 16'd0);
    drive(1'b1, 16'd7, 32'h0, 32'd9, 8'd3, 1'b1);
    tick();
    chk_out("fresh1", 1'b1, 32'h302, 1'b0, 1'b1, 1'b0, 16'd1);
    tick();
    chk_out("fresh2", 1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 16'd2);
    tick();
    chk_out("fresh_done", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd3);
    tick();
    chk_out("start_in_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd3);
    drive(1'b0, 16'd0, 32'h0, 32'd0, 8'd0, 1'b1);
    tick();
    chk_out("idle_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
